// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between mem_stage (master) and the data memory (slave).
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory-access stage: EX/MEM register, data-memory handshake, MEM->WB register.
// Optional access timeout is built in when MEM_TIMEOUT_EN is defined.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ex_valid,
    input  logic [15:0] ex_alu_result,
    input  logic [15:0] ex_store_data,
    input  logic [2:0]  ex_write_reg_addr,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,

    output logic        mem_stall,
    mem_stage_if.master dmem,

    output logic [15:0] mem_forward_data,
    output logic        mem_reg_write,
    output logic [2:0]  mem_write_reg_addr,
    output logic        mem_is_load,

    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [2:0]  wb_write_reg_addr,
    output logic [15:0] wb_data,
    output logic        mem_error
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t state;
    state_t state_next;

    logic        m_valid;
    logic [15:0] m_alu_result;
    logic [15:0] m_store_data;
    logic [2:0]  m_write_reg_addr;
    logic        m_mem_read;
    logic        m_mem_write;
    logic        m_reg_write;
    logic        m_mem_to_reg;

    logic        m_is_store;
    logic        capture_mem;
    logic        pending;
    logic        ack_done;
    logic        abort;
    logic        req;
    logic        we;

    // Load wins when both read and write are set.
    assign m_is_store  = m_mem_write & ~m_mem_read;
    assign capture_mem = ~mem_stall & ex_valid & (ex_mem_read | ex_mem_write);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 4) ? 4 : CNT_RAW;

    logic [CNT_W-1:0] wait_cnt;

    // Every state entry happens on a non-stalled edge, so clearing there covers it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!mem_stall) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign abort = (state == BUSY) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_error <= 1'b0;
        end else if (abort) begin
            mem_error <= 1'b1;
        end
    end
`else
    assign abort     = 1'b0;
    assign mem_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (capture_mem) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (ack_done || abort) begin
                    state_next = capture_mem ? BUSY : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // An aborted access drops its request, so an ack in that cycle is ignored.
    always_comb begin
        pending   = (state == BUSY) && !abort;
        req       = pending;
        we        = pending & m_is_store;
        ack_done  = pending & dmem.dmem_ack;
        mem_stall = pending & ~dmem.dmem_ack;
    end

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = we;
    assign dmem.dmem_addr  = m_alu_result;
    assign dmem.dmem_wdata = m_store_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid          <= 1'b0;
            m_alu_result     <= '0;
            m_store_data     <= '0;
            m_write_reg_addr <= '0;
            m_mem_read       <= 1'b0;
            m_mem_write      <= 1'b0;
            m_reg_write      <= 1'b0;
            m_mem_to_reg     <= 1'b0;
        end else if (!mem_stall) begin
            m_valid          <= ex_valid;
            m_alu_result     <= ex_alu_result;
            m_store_data     <= ex_store_data;
            m_write_reg_addr <= ex_write_reg_addr;
            m_mem_read       <= ex_mem_read;
            m_mem_write      <= ex_mem_write;
            m_reg_write      <= ex_reg_write;
            m_mem_to_reg     <= ex_mem_to_reg;
        end
    end

    assign mem_forward_data   = m_alu_result;
    assign mem_reg_write      = m_valid & m_reg_write;
    assign mem_write_reg_addr = m_write_reg_addr;
    assign mem_is_load        = m_valid & m_mem_read;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid          <= 1'b0;
            wb_reg_write      <= 1'b0;
            wb_write_reg_addr <= '0;
            wb_data           <= '0;
        end else if (!mem_stall) begin
            wb_valid          <= m_valid;
            wb_reg_write      <= m_valid & m_reg_write & ~m_is_store & ~abort;
            wb_write_reg_addr <= m_write_reg_addr;
            if (abort) begin
                wb_data <= '1;
            end else if (m_mem_to_reg) begin
                wb_data <= dmem.dmem_rdata;
            end else begin
                wb_data <= m_alu_result;
            end
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; timeout scenario runs only with MEM_TIMEOUT_EN.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ex_alu_result;
    logic [15:0] ex_store_data;
    logic [2:0]  ex_write_reg_addr;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        ex_mem_to_reg;
    logic        mem_stall;
    logic [15:0] mem_forward_data;
    logic        mem_reg_write;
    logic [2:0]  mem_write_reg_addr;
    logic        mem_is_load;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [2:0]  wb_write_reg_addr;
    logic [15:0] wb_data;
    logic        mem_error;

    int checks = 0;
    int errors = 0;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT_CYCLES(15)) dut (
        .clk                (clk),
        .rst                (rst),
        .ex_valid           (ex_valid),
        .ex_alu_result      (ex_alu_result),
        .ex_store_data      (ex_store_data),
        .ex_write_reg_addr  (ex_write_reg_addr),
        .ex_mem_read        (ex_mem_read),
        .ex_mem_write       (ex_mem_write),
        .ex_reg_write       (ex_reg_write),
        .ex_mem_to_reg      (ex_mem_to_reg),
        .mem_stall          (mem_stall),
        .dmem               (bus),
        .mem_forward_data   (mem_forward_data),
        .mem_reg_write      (mem_reg_write),
        .mem_write_reg_addr (mem_write_reg_addr),
        .mem_is_load        (mem_is_load),
        .wb_valid           (wb_valid),
        .wb_reg_write       (wb_reg_write),
        .wb_write_reg_addr  (wb_write_reg_addr),
        .wb_data            (wb_data),
        .mem_error          (mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                          input logic [2:0] rd, input logic rd_en, input logic wr_en,
                          input logic rw, input logic m2r);
        ex_valid          = v;
        ex_alu_result     = alu;
        ex_store_data     = sd;
        ex_write_reg_addr = rd;
        ex_mem_read       = rd_en;
        ex_mem_write      = wr_en;
        ex_reg_write      = rw;
        ex_mem_to_reg     = m2r;
    endtask

    task automatic bubble();
        set_ex(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset(input string p);
        check({p, "_stall"},  16'(mem_stall), 16'h0);
        check({p, "_req"},    16'(bus.dmem_req), 16'h0);
        check({p, "_we"},     16'(bus.dmem_we), 16'h0);
        check({p, "_addr"},   bus.dmem_addr, 16'h0000);
        check({p, "_wdata"},  bus.dmem_wdata, 16'h0000);
        check({p, "_fwd"},    mem_forward_data, 16'h0000);
        check({p, "_mrw"},    16'(mem_reg_write), 16'h0);
        check({p, "_mrd"},    16'(mem_write_reg_addr), 16'h0);
        check({p, "_mld"},    16'(mem_is_load), 16'h0);
        check({p, "_wbv"},    16'(wb_valid), 16'h0);
        check({p, "_wbrw"},   16'(wb_reg_write), 16'h0);
        check({p, "_wbrd"},   16'(wb_write_reg_addr), 16'h0);
        check({p, "_wbdata"}, wb_data, 16'h0000);
        check({p, "_err"},    16'(mem_error), 16'h0);
    endtask

    initial begin
        rst = 1'b1;
        bubble();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 16'h0000;
        tick();
        tick();
        check_reset("rst");
        rst = 1'b0;

        // ALU op to r3
        set_ex(1'b1, 16'h00B0, 16'h0000, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 check("alu_stall0", 16'(mem_stall), 16'h0);
        tick();
        bubble();
        #1;
        check("alu_fwd", mem_forward_data, 16'h00B0);
        check("alu_mrw", 16'(mem_reg_write), 16'h1);
        check("alu_mrd", 16'(mem_write_reg_addr), 16'h3);
        check("alu_mld", 16'(mem_is_load), 16'h0);
        check("alu_stall1", 16'(mem_stall), 16'h0);
        check("alu_req", 16'(bus.dmem_req), 16'h0);
        tick();
        check("alu_wbv", 16'(wb_valid), 16'h1);
        check("alu_wbrw", 16'(wb_reg_write), 16'h1);
        check("alu_wbrd", 16'(wb_write_reg_addr), 16'h3);
        check("alu_wbdata", wb_data, 16'h00B0);

        // Load r2 <- [0x0010], two wait cycles
        set_ex(1'b1, 16'h0010, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        bubble();
        #1;
        check("ld_req", 16'(bus.dmem_req), 16'h1);
        check("ld_we", 16'(bus.dmem_we), 16'h0);
        check("ld_stall_w1", 16'(mem_stall), 16'h1);
        check("ld_addr_w1", bus.dmem_addr, 16'h0010);
        check("ld_mld", 16'(mem_is_load), 16'h1);
        tick();
        check("ld_bubble1", 16'(wb_valid), 16'h0);
        check("ld_stall_w2", 16'(mem_stall), 16'h1);
        check("ld_addr_w2", bus.dmem_addr, 16'h0010);
        tick();
        check("ld_bubble2", 16'(wb_valid), 16'h0);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 16'h1234;
        #1;
        check("ld_stall_ack", 16'(mem_stall), 16'h0);
        check("ld_addr_ack", bus.dmem_addr, 16'h0010);
        tick();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 16'h0000;
        #1;
        check("ld_wbv", 16'(wb_valid), 16'h1);
        check("ld_wbrw", 16'(wb_reg_write), 16'h1);
        check("ld_wbrd", 16'(wb_write_reg_addr), 16'h2);
        check("ld_wbdata", wb_data, 16'h1234);
        check("ld_req_done", 16'(bus.dmem_req), 16'h0);

        // Store 0xBEEF -> [0x0004] (illegal reg_write set), zero wait, then ADD r4
        set_ex(1'b1, 16'h0004, 16'hBEEF, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        set_ex(1'b1, 16'h0077, 16'h0000, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.dmem_ack = 1'b1;
        #1;
        check("st_req", 16'(bus.dmem_req), 16'h1);
        check("st_we", 16'(bus.dmem_we), 16'h1);
        check("st_addr", bus.dmem_addr, 16'h0004);
        check("st_wdata", bus.dmem_wdata, 16'hBEEF);
        check("st_stall", 16'(mem_stall), 16'h0);
        tick();
        bus.dmem_ack = 1'b0;
        bubble();
        #1;
        check("st_wbv", 16'(wb_valid), 16'h1);
        check("st_wbrw", 16'(wb_reg_write), 16'h0);
        check("st_wbdata", wb_data, 16'h0004);
        check("st_we_off", 16'(bus.dmem_we), 16'h0);
        check("add_fwd", mem_forward_data, 16'h0077);
        check("add_stall", 16'(mem_stall), 16'h0);
        tick();
        check("add_wbv", 16'(wb_valid), 16'h1);
        check("add_wbrw", 16'(wb_reg_write), 16'h1);
        check("add_wbrd", 16'(wb_write_reg_addr), 16'h4);
        check("add_wbdata", wb_data, 16'h0077);

        // Back-to-back loads, one wait cycle each
        set_ex(1'b1, 16'h0020, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        set_ex(1'b1, 16'h0030, 16'h0000, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        check("b2b1_stall", 16'(mem_stall), 16'h1);
        check("b2b1_addr", bus.dmem_addr, 16'h0020);
        tick();
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 16'hAAAA;
        #1;
        check("b2b1_stall_ack", 16'(mem_stall), 16'h0);
        tick();
        bubble();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 16'h0000;
        #1;
        check("b2b1_wbdata", wb_data, 16'hAAAA);
        check("b2b1_wbrd", 16'(wb_write_reg_addr), 16'h1);
        check("b2b1_wbrw", 16'(wb_reg_write), 16'h1);
        check("b2b2_req", 16'(bus.dmem_req), 16'h1);
        check("b2b2_addr", bus.dmem_addr, 16'h0030);
        check("b2b2_stall", 16'(mem_stall), 16'h1);
        tick();
        check("b2b2_bubble", 16'(wb_valid), 16'h0);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 16'h5555;
        #1;
        check("b2b2_stall_ack", 16'(mem_stall), 16'h0);
        tick();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 16'h0000;
        #1;
        check("b2b2_wbv", 16'(wb_valid), 16'h1);
        check("b2b2_wbdata", wb_data, 16'h5555);
        check("b2b2_wbrd", 16'(wb_write_reg_addr), 16'h6);
        check("b2b2_req_done", 16'(bus.dmem_req), 16'h0);

        // Stray ack while idle is ignored
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 16'hDEAD;
        #1;
        check("stray_stall", 16'(mem_stall), 16'h0);
        tick();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 16'h0000;
        #1;
        check("stray_wbv", 16'(wb_valid), 16'h0);

        // Read and write both set behaves as a load
        set_ex(1'b1, 16'h0040, 16'h1111, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        bubble();
        #1;
        check("rw_we", 16'(bus.dmem_we), 16'h0);
        check("rw_req", 16'(bus.dmem_req), 16'h1);
        check("rw_mld", 16'(mem_is_load), 16'h1);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 16'h0F0F;
        tick();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 16'h0000;
        #1;
        check("rw_wbrw", 16'(wb_reg_write), 16'h1);
        check("rw_wbdata", wb_data, 16'h0F0F);
        check("rw_wbrd", 16'(wb_write_reg_addr), 16'h7);

        // Reset in the middle of a pending load, late ack ignored
        set_ex(1'b1, 16'h0050, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        bubble();
        #1;
        check("rmid_req", 16'(bus.dmem_req), 16'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_reset("rmid");
        tick();
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 16'h9999;
        #1;
        check("rmid_late_stall", 16'(mem_stall), 16'h0);
        tick();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 16'h0000;
        #1;
        check("rmid_late_wbv", 16'(wb_valid), 16'h0);

`ifdef MEM_TIMEOUT_EN
        // Load never acknowledged: 15 stall cycles, then abort
        set_ex(1'b1, 16'h0060, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        bubble();
        #1;
        for (int i = 0; i < 15; i++) begin
            check($sformatf("to_stall_%0d", i), 16'(mem_stall), 16'h1);
            tick();
        end
        check("to_abort_stall", 16'(mem_stall), 16'h0);
        check("to_abort_req", 16'(bus.dmem_req), 16'h0);
        tick();
        check("to_wbv", 16'(wb_valid), 16'h1);
        check("to_wbrw", 16'(wb_reg_write), 16'h0);
        check("to_wbdata", wb_data, 16'hFFFF);
        check("to_err", 16'(mem_error), 16'h1);
        check("to_state_idle_req", 16'(bus.dmem_req), 16'h0);
        tick();
        tick();
        check("to_err_sticky", 16'(mem_error), 16'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("to_err_cleared", 16'(mem_error), 16'h0);
`else
        check("err_tied_low", 16'(mem_error), 16'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline memory-access stage of the 16-bit core. It sits directly downstream of the execute stage. It latches the execute-stage results into the EX/MEM register and runs the data-memory request/acknowledge handshake for loads and stores. While an access waits, it stalls the upstream pipeline; it then delivers the registered write-back bundle to the WB stage. It also exports the MEM-stage forwarding value and destination information consumed by the execute stage's forwarding muxes and the hazard unit.

## Interface
Parameters:
- TIMEOUT_CYCLES, 15: maximum wait cycles per access before abort; only used when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- ex_valid  in  1  EX holds a real instruction (0 = bubble)
- ex_alu_result  in  16  ALU result; memory address for load/store
- ex_store_data  in  16  forwarded rt value for stores
- ex_write_reg_addr  in  3  destination register (7 for JAL)
- ex_mem_read / ex_mem_write  in  1 each  load / store
- ex_reg_write / ex_mem_to_reg  in  1 each  write-back enable / select memory data
- mem_stall  out  1  freeze IF/ID/EX and hold EX outputs stable
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  16  word address
- dmem_wdata  out  16  store data
- dmem_ack  in  1  access complete this cycle
- dmem_rdata  in  16  load data, valid when dmem_ack=1
- mem_forward_data  out  16  EX/MEM alu_result (forward_a/forward_b = 01 source)
- mem_reg_write  out  1  EX/MEM valid & reg_write
- mem_write_reg_addr  out  3  EX/MEM destination
- mem_is_load  out  1  EX/MEM holds a load (hazard unit must not forward)
- wb_valid  out  1  WB bundle valid
- wb_reg_write  out  1  write-back enable
- wb_write_reg_addr  out  3  write-back destination
- wb_data  out  16  write-back data
- mem_error  out  1  sticky timeout flag; constant 0 without MEM_TIMEOUT_EN

## Operation
- EX/MEM register loads all ex_* fields on each rising edge where mem_stall=0. It holds while mem_stall=1.
- FSM states IDLE and BUSY:
  - IDLE→BUSY when the register captures ex_valid & (ex_mem_read | ex_mem_write).
  - BUSY→IDLE on dmem_ack unless a new memory op is captured on the same edge; in that case it stays BUSY.
- In BUSY:
  - dmem_req=1; dmem_we, dmem_addr and dmem_wdata are driven from the EX/MEM register and stay stable until ack.
  - mem_stall = BUSY & ~dmem_ack.
- Non-memory instructions and bubbles never stall.
- dmem_ack while dmem_req=0 is ignored.
- WB register loads on every edge where mem_stall=0:
  - wb_valid = mem valid.
  - wb_reg_write = valid & reg_write.
  - wb_data = dmem_rdata if mem_to_reg, else alu_result.
- On edges where mem_stall=1, WB gets a bubble: wb_valid=0, wb_reg_write=0, other fields hold.
- A store with reg_write=1 is illegal; the block forces wb_reg_write=0 for stores.
- If mem_read and mem_write are both set, the instruction is treated as a load.
- Reset mid-access: the next cycle shows dmem_req=0 and state IDLE, and a late ack is ignored.

## Timing
- Reset values of every output:
  - mem_stall=0, dmem_req=0, dmem_we=0.
  - dmem_addr=0, dmem_wdata=0.
  - mem_forward_data=0, mem_reg_write=0, mem_write_reg_addr=0, mem_is_load=0.
  - wb_valid=0, wb_reg_write=0, wb_write_reg_addr=0, wb_data=0, mem_error=0.
- Non-memory op:
  - Captured at edge E; visible on mem_* outputs after E.
  - Visible on wb_* after E+1.
- Memory op with N wait cycles (ack in the (N+1)th BUSY cycle):
  - mem_stall high for N cycles.
  - wb_* valid after edge E+1+N.
  - Zero-wait ack (N=0) gives no stall.
- mem_forward_data is combinational from the EX/MEM register and stable for the whole stall.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A 4-bit-or-wider cycle counter runs in BUSY and clears on state entry.
  - After TIMEOUT_CYCLES BUSY cycles without ack, the access is aborted: dmem_req drops and mem_stall drops for that cycle.
  - The instruction retires to WB with wb_reg_write=0 and wb_data=16'hFFFF, and mem_error is set.
  - mem_error clears only on rst.
- MEM_TIMEOUT_EN undefined:
  - No counter; BUSY waits indefinitely for dmem_ack.
  - mem_error tied to 0.

## Test plan
- Reset with a load pending: assert rst during BUSY → next cycle all outputs are at their reset values, and an ack 2 cycles later produces no wb_valid.
- ALU op, alu_result=16'h00B0, dest 3 → mem_forward_data=16'h00B0 one cycle later, then wb_valid=1, wb_reg_write=1, wb_write_reg_addr=3, wb_data=16'h00B0, with mem_stall never asserted.
- Load from addr 16'h0010 with ack after 2 wait cycles, rdata=16'h1234 → mem_stall high for exactly 2 cycles, dmem_addr stable, two WB bubbles, then wb_data=16'h1234 with wb_reg_write=1.
- Store data 16'hBEEF to 16'h0004 with zero-wait ack, followed by an ADD → dmem_we=1 for one cycle, no stall, WB shows the store with wb_reg_write=0, then the ADD on the next cycle.
- Back-to-back loads each acked after 1 wait → FSM stays BUSY across the boundary, 1 stall cycle per load, results retire in order.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=15, a load never acked → stall lasts 15 cycles, then wb_data=16'hFFFF, wb_reg_write=0 and mem_error=1 until rst.
